// File: rtl/wb_to_ahb3lite_master_if.sv
// Signal bundle between the SD-controller Wishbone DMA master and the AHB-Lite
// fabric. The bridge connects through the master modport, the environment
// (Wishbone initiator plus AHB slave) through the slave modport.
interface wb_to_ahb3lite_master_if;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic [31:0] wbs_dat_o;
   logic [3:0]  wbs_sel_i;
   logic        wbs_we_i;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic [2:0]  wbs_cti_i;
   logic [1:0]  wbs_bte_i;
   logic        wbs_ack_o;
   logic        wbs_err_o;
   logic [31:0] mHADDR;
   logic [31:0] mHWDATA;
   logic        mHWRITE;
   logic [2:0]  mHSIZE;
   logic [2:0]  mHBURST;
   logic [1:0]  mHTRANS;
   logic [3:0]  mHPROT;
   logic [31:0] mHRDATA;
   logic        mHREADY;
   logic        mHRESP;

   modport master (
      input  wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_cyc_i, wbs_stb_i,
      input  wbs_cti_i, wbs_bte_i,
      output wbs_dat_o, wbs_ack_o, wbs_err_o,
      output mHADDR, mHWDATA, mHWRITE, mHSIZE, mHBURST, mHTRANS, mHPROT,
      input  mHRDATA, mHREADY, mHRESP
   );

   modport slave (
      output wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_cyc_i, wbs_stb_i,
      output wbs_cti_i, wbs_bte_i,
      input  wbs_dat_o, wbs_ack_o, wbs_err_o,
      input  mHADDR, mHWDATA, mHWRITE, mHSIZE, mHBURST, mHTRANS, mHPROT,
      output mHRDATA, mHREADY, mHRESP
   );
endinterface

// File: rtl/wb_to_ahb3lite_master.sv
// Wishbone classic slave to AHB-Lite master bridge. Every Wishbone access becomes
// one SINGLE AHB transfer; only one transfer is ever outstanding. Byte-lane
// selects are translated into HSIZE plus the low address bits.
module wb_to_ahb3lite_master #(
   parameter logic [3:0] HPROT_VAL = 4'b0011
) (
   input logic wb_clk_i,
   input logic wb_rst_i,
   wb_to_ahb3lite_master_if.master bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t      state;
   state_t      state_next;
   logic        request;
   logic        sel_legal;
   logic [2:0]  sel_size;
   logic [1:0]  sel_lo;
   logic [31:0] haddr;
   logic [31:0] hwdata;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [31:0] rdata;
   logic        err_flag;
   logic        dropped;
   logic [1:0]  htrans;
   logic        ack;
   logic        err;
   logic        unused_ok;

   assign request   = bus.wbs_cyc_i & bus.wbs_stb_i;
   assign unused_ok = ^{bus.wbs_cti_i, bus.wbs_bte_i, bus.wbs_adr_i[1:0]};

   // Translate the byte-lane pattern into an AHB size and address offset
   always_comb begin
      sel_legal = 1'b1;
      sel_size  = 3'b010;
      sel_lo    = 2'b00;
      case (bus.wbs_sel_i)
         4'b1111: begin sel_size = 3'b010; sel_lo = 2'b00; end
         4'b0011: begin sel_size = 3'b001; sel_lo = 2'b00; end
         4'b1100: begin sel_size = 3'b001; sel_lo = 2'b10; end
         4'b0001: begin sel_size = 3'b000; sel_lo = 2'b00; end
         4'b0010: begin sel_size = 3'b000; sel_lo = 2'b01; end
         4'b0100: begin sel_size = 3'b000; sel_lo = 2'b10; end
         4'b1000: begin sel_size = 3'b000; sel_lo = 2'b11; end
         default: sel_legal = 1'b0;
      endcase
   end

   // State register
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) state <= IDLE;
      else          state <= state_next;
   end

   // Next-state decode plus HTRANS and the Wishbone termination strobes
   always_comb begin
      state_next = state;
      htrans     = 2'b00;
      ack        = 1'b0;
      err        = 1'b0;
      case (state)
         IDLE: begin
            if (request) state_next = sel_legal ? ADDR : RESP;
         end
         ADDR: begin
            htrans = 2'b10;
            if (bus.mHREADY) state_next = DATA;
         end
         DATA: begin
            if (bus.mHREADY) state_next = RESP;
         end
         RESP: begin
            ack        = ~err_flag & ~dropped & bus.wbs_cyc_i;
            err        = err_flag & ~dropped & bus.wbs_cyc_i;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Latch the request, capture the AHB response and note abandoned cycles
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         haddr    <= '0;
         hwdata   <= '0;
         hwrite   <= 1'b0;
         hsize    <= 3'b010;
         rdata    <= '0;
         err_flag <= 1'b0;
         dropped  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (request) begin
                  err_flag <= ~sel_legal;
                  dropped  <= 1'b0;
                  if (sel_legal) begin
                     haddr  <= {bus.wbs_adr_i[31:2], sel_lo};
                     hwdata <= bus.wbs_dat_i;
                     hwrite <= bus.wbs_we_i;
                     hsize  <= sel_size;
                  end
               end
            end
            DATA: begin
               if (bus.mHREADY) begin
                  err_flag <= bus.mHRESP;
                  if (!bus.mHRESP && !hwrite) rdata <= bus.mHRDATA;
               end
            end
            default: ;
         endcase
         if (state != IDLE && !bus.wbs_cyc_i) dropped <= 1'b1;
      end
   end

   assign bus.mHADDR    = haddr;
   assign bus.mHWDATA   = hwdata;
   assign bus.mHWRITE   = hwrite;
   assign bus.mHSIZE    = hsize;
   assign bus.mHBURST   = 3'b000;
   assign bus.mHTRANS   = htrans;
   assign bus.mHPROT    = HPROT_VAL;
   assign bus.wbs_dat_o = rdata;
   assign bus.wbs_ack_o = ack;
   assign bus.wbs_err_o = err;

endmodule

// File: tb/tb_wb_to_ahb3lite_master.sv
// Self-checking bench for wb_to_ahb3lite_master. Each Wishbone access is described
// as a timeline (address stalls, data waits, error, drop, reset) and a
// transaction-level model predicts every cycle's outputs from that timeline.
module tb_wb_to_ahb3lite_master;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int checks   = 0;
   int failures = 0;

   bit          chk_en    = 1'b0;
   bit          chk_rst   = 1'b0;
   bit          chk_addr  = 1'b0;
   bit          chk_wdata = 1'b0;
   logic [1:0]  exp_htrans = 2'b00;
   logic        exp_ack    = 1'b0;
   logic        exp_err    = 1'b0;
   logic [31:0] exp_haddr  = '0;
   logic [31:0] exp_hwdata = '0;
   logic [2:0]  exp_hsize  = 3'b010;
   logic        exp_hwrite = 1'b0;
   logic [31:0] model_dat  = '0;

   int          cur_k = 0;
   int          obs_ack_k;
   int          obs_err_k;
   int          obs_nonseq_cnt;
   logic [31:0] obs_haddr;
   logic [31:0] obs_hwdata2;
   logic [2:0]  obs_hsize;
   logic        obs_hwrite;

   wb_to_ahb3lite_master_if bus();

   wb_to_ahb3lite_master #(.HPROT_VAL(4'b0011)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Legal lane patterns are one byte, an aligned halfword or the whole word
   function automatic void modelSel(input logic [3:0] sel, output bit legal,
                                    output logic [1:0] lo, output logic [2:0] size);
      int n = 0;
      int lowest = -1;
      for (int i = 0; i < 4; i++) begin
         if (sel[i]) begin
            n++;
            if (lowest < 0) lowest = i;
         end
      end
      legal = (n == 1) || (n == 4);
      if (n == 2 && (lowest % 2) == 0) legal = sel[lowest + 1];
      size = (n == 1) ? 3'b000 : (n == 2) ? 3'b001 : 3'b010;
      lo   = (n == 4 || lowest < 0) ? 2'b00 : 2'(lowest);
   endfunction

   // Compare every DUT output with the model each cycle, away from the clock edge
   always @(negedge clk) begin
      if (chk_en) begin
         checkOutput("htrans", 32'(bus.mHTRANS), 32'(exp_htrans));
         checkOutput("ack", 32'(bus.wbs_ack_o), 32'(exp_ack));
         checkOutput("err", 32'(bus.wbs_err_o), 32'(exp_err));
         checkOutput("dat_o", bus.wbs_dat_o, model_dat);
         checkOutput("hprot", 32'(bus.mHPROT), 32'h3);
         checkOutput("hburst", 32'(bus.mHBURST), 32'h0);
         if (chk_addr) begin
            checkOutput("haddr", bus.mHADDR, exp_haddr);
            checkOutput("hsize", 32'(bus.mHSIZE), 32'(exp_hsize));
            checkOutput("hwrite", 32'(bus.mHWRITE), 32'(exp_hwrite));
         end
         if (chk_wdata) checkOutput("hwdata", bus.mHWDATA, exp_hwdata);
         if (chk_rst) begin
            checkOutput("rst_haddr", bus.mHADDR, 32'h0);
            checkOutput("rst_hwdata", bus.mHWDATA, 32'h0);
            checkOutput("rst_hwrite", 32'(bus.mHWRITE), 32'h0);
            checkOutput("rst_hsize", 32'(bus.mHSIZE), 32'h2);
         end
         if (bus.mHTRANS == 2'b10) begin
            if (obs_nonseq_cnt == 0) begin
               obs_haddr  = bus.mHADDR;
               obs_hsize  = bus.mHSIZE;
               obs_hwrite = bus.mHWRITE;
            end
            obs_nonseq_cnt++;
         end
         if (bus.wbs_ack_o === 1'b1 && obs_ack_k < 0) obs_ack_k = cur_k;
         if (bus.wbs_err_o === 1'b1 && obs_err_k < 0) obs_err_k = cur_k;
         if (cur_k == 2) obs_hwdata2 = bus.mHWDATA;
      end
   end

   task automatic setIdleExpect();
      exp_htrans = 2'b00;
      exp_ack    = 1'b0;
      exp_err    = 1'b0;
      chk_addr   = 1'b0;
      chk_wdata  = 1'b0;
   endtask

   task automatic driveIdle();
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.mHREADY   = 1'b1;
      bus.mHRESP    = 1'b0;
      bus.mHRDATA   = $urandom;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         driveIdle();
         setIdleExpect();
         cur_k++;
         @(posedge clk); #1;
         chk_rst = 1'b0;
      end
   endtask

   // One Wishbone access: a = address-phase stalls, d = data-phase waits,
   // drop_k = cycle cyc falls (0 none), rst_k = cycle reset is raised (-1 none)
   task automatic applyStimulus(input logic [31:0] adr, input logic [31:0] dat,
                                input logic [3:0] sel, input bit we, input int a,
                                input int d, input bit ahb_err, input logic [31:0] rd,
                                input int drop_k, input int rst_k);
      bit         legal;
      bit         dropped;
      bit         in_addr;
      bit         in_data;
      logic [1:0] lo;
      logic [2:0] size;
      int         r;
      modelSel(sel, legal, lo, size);
      r = legal ? 3 + a + d : 1;
      obs_ack_k      = -1;
      obs_err_k      = -1;
      obs_nonseq_cnt = 0;
      obs_haddr      = '0;
      obs_hsize      = '0;
      obs_hwrite     = 1'b0;
      obs_hwdata2    = '0;
      for (int k = 0; k <= r; k++) begin
         cur_k   = k;
         dropped = (drop_k > 0) && (k >= drop_k);
         bus.wbs_cyc_i = !dropped;
         bus.wbs_stb_i = !dropped;
         bus.wbs_adr_i = adr;
         bus.wbs_dat_i = dat;
         bus.wbs_sel_i = sel;
         bus.wbs_we_i  = we;
         bus.wbs_cti_i = 3'($urandom);
         bus.wbs_bte_i = 2'($urandom);
         bus.mHREADY   = !(legal && ((k >= 1 && k <= a) || (k >= 2 + a && k <= 1 + a + d)));
         bus.mHRESP    = legal && ahb_err && (k == 1 + a + d || k == 2 + a + d);
         bus.mHRDATA   = (k == 2 + a + d) ? rd : $urandom;
         in_addr    = legal && k >= 1 && k <= 1 + a;
         in_data    = legal && k >= 2 + a && k <= 2 + a + d;
         exp_htrans = in_addr ? 2'b10 : 2'b00;
         chk_addr   = in_addr;
         exp_haddr  = {adr[31:2], lo};
         exp_hsize  = size;
         exp_hwrite = we;
         chk_wdata  = in_data && we;
         exp_hwdata = dat;
         exp_ack    = (k == r) && !dropped && legal && !ahb_err;
         exp_err    = (k == r) && !dropped && (!legal || ahb_err);
         if (k == r && legal && !we && !ahb_err) model_dat = rd;
         rst = (k == rst_k);
         @(posedge clk); #1;
         if (k == rst_k) begin
            rst       = 1'b0;
            model_dat = '0;
            chk_rst   = 1'b1;
            break;
         end
      end
      idleCycles(1);
   endtask

   // Directed scenarios with literal expectations, then randomized traffic
   initial begin
      logic [3:0]  sel;
      logic [31:0] rd;
      bit          we;
      bit          ahb_err;
      bit          legal;
      logic [1:0]  lo_unused;
      logic [2:0]  size_unused;
      int          a;
      int          d;
      int          drop_k;
      bus.wbs_adr_i = '0;
      bus.wbs_dat_i = '0;
      bus.wbs_sel_i = '0;
      bus.wbs_we_i  = 1'b0;
      bus.wbs_cti_i = '0;
      bus.wbs_bte_i = '0;
      driveIdle();
      repeat (2) @(posedge clk);
      #1;
      chk_en  = 1'b1;
      chk_rst = 1'b1;
      setIdleExpect();
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk_rst = 1'b0;

      applyStimulus(32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, 1'b1, 0, 0, 1'b0, 32'h0, 0, -1);
      checkOutput("w27_nonseq_addr", obs_haddr, 32'h8000_0010);
      checkOutput("w27_nonseq_size", 32'(obs_hsize), 32'h2);
      checkOutput("w27_nonseq_write", 32'(obs_hwrite), 32'h1);
      checkOutput("w27_hwdata_n2", obs_hwdata2, 32'hDEAD_BEEF);
      checkOutput("w27_ack_cycle", 32'(obs_ack_k), 32'd3);

      applyStimulus(32'h0000_0100, 32'h0, 4'b0100, 1'b0, 0, 2, 1'b0, 32'h00AB_0000, 0, -1);
      checkOutput("r28_nonseq_addr", obs_haddr, 32'h0000_0102);
      checkOutput("r28_nonseq_size", 32'(obs_hsize), 32'h0);
      checkOutput("r28_ack_cycle", 32'(obs_ack_k), 32'd5);
      checkOutput("r28_dat_o", bus.wbs_dat_o, 32'h00AB_0000);

      applyStimulus(32'h0000_0300, 32'h1234_5678, 4'b0110, 1'b1, 0, 0, 1'b0, 32'h0, 0, -1);
      checkOutput("i29_nonseq_count", 32'(obs_nonseq_cnt), 32'd0);
      checkOutput("i29_err_cycle", 32'(obs_err_k), 32'd1);
      checkOutput("i29_ack_cycle", 32'(obs_ack_k), 32'hFFFF_FFFF);
      checkOutput("i29_dat_o", bus.wbs_dat_o, 32'h00AB_0000);

      applyStimulus(32'h0000_0200, 32'h0, 4'b1111, 1'b0, 0, 1, 1'b1, 32'h5555_AAAA, 0, -1);
      checkOutput("e30_err_cycle", 32'(obs_err_k), 32'd4);
      checkOutput("e30_ack_cycle", 32'(obs_ack_k), 32'hFFFF_FFFF);
      checkOutput("e30_nonseq_count", 32'(obs_nonseq_cnt), 32'd1);
      checkOutput("e30_dat_o", bus.wbs_dat_o, 32'h00AB_0000);

      applyStimulus(32'h0000_0040, 32'hCAFE_F00D, 4'b1111, 1'b1, 3, 0, 1'b0, 32'h0, 4, -1);
      checkOutput("d31_nonseq_count", 32'(obs_nonseq_cnt), 32'd4);
      checkOutput("d31_ack_cycle", 32'(obs_ack_k), 32'hFFFF_FFFF);
      checkOutput("d31_err_cycle", 32'(obs_err_k), 32'hFFFF_FFFF);

      applyStimulus(32'h0000_0080, 32'h0, 4'b1111, 1'b0, 0, 2, 1'b0, 32'h7777_1111, 0, 3);
      idleCycles(2);
      checkOutput("x31_ack_after_reset", 32'(obs_ack_k), 32'hFFFF_FFFF);
      checkOutput("x31_dat_o", bus.wbs_dat_o, 32'h0);

      for (int t = 0; t < 60; t++) begin
         sel     = 4'($urandom_range(0, 15));
         we      = 1'($urandom);
         a       = $urandom_range(0, 3);
         d       = $urandom_range(0, 3);
         ahb_err = ($urandom_range(0, 4) == 0);
         if (ahb_err && d == 0) d = 1;
         rd      = $urandom;
         modelSel(sel, legal, lo_unused, size_unused);
         drop_k  = 0;
         if (legal && we && $urandom_range(0, 5) == 0) drop_k = $urandom_range(1, 2 + a + d);
         applyStimulus($urandom, $urandom, sel, we, a, d, ahb_err, rd, drop_k, -1);
         if ($urandom_range(0, 2) == 0) idleCycles($urandom_range(1, 2));
      end

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
